// File: rtl/char_motion_if.sv
`default_nettype none
// ============================================================================
// Module   : char_motion_if
// Purpose  : Collision-RAM read port between the character motion engine
//            (master) and the collision map memory (slave).
// Signals  : coll_addr  [ADDR_W-1:0]  read address, driven by the master
//            coll_data                1 = solid, returned MEM_LAT cycles later
// Revision : 1.0  initial release
// ============================================================================
interface char_motion_if #(
  parameter int ADDR_W = 19
) ();

  logic [ADDR_W-1:0] coll_addr;
  logic              coll_data;

  modport master (output coll_addr, input  coll_data);
  modport slave  (input  coll_addr, output coll_data);

endinterface
`default_nettype wire

// File: rtl/char_motion.sv
`default_nettype none
// ============================================================================
// Module   : char_motion
// Purpose  : Tick-driven platformer character motion. On every motion tick
//            the keypad is latched, a horizontal step is probed against the
//            collision RAM, then a vertical step (jump / fall / ground check)
//            is probed from the post-horizontal position.
// Ports    : sys_clk   in   sole clock
//            rst       in   asynchronous active-high reset
//            mov[3:0]  in   keypad {up, down, left, right}
//            coll      if   collision-RAM read port (master side)
//            char_X    out  character X position
//            char_Y    out  character Y position
//            vmode     out  0 GROUND, 1 FALL, 2 JUMP
//            busy      out  high while a tick's probe sequence is running
// Revision : 1.0  initial release
// ============================================================================
module char_motion #(
  parameter int MAP_W      = 960,
  parameter int MAP_H      = 500,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int TICK_DIV   = 200000,
  parameter int JUMP_TICKS = 48,
  parameter int MEM_LAT    = 1,
  parameter int START_X    = 244,
  parameter int START_Y    = 350
) (
  input  wire logic           sys_clk,
  input  wire logic           rst,
  input  wire logic [3:0]     mov,
  char_motion_if.master       coll,
  output logic [X_W-1:0]      char_X,
  output logic [Y_W-1:0]      char_Y,
  output logic [1:0]          vmode,
  output logic                busy
);

  localparam int ADDR_W = $clog2(MAP_W * MAP_H);
  localparam int TC_W   = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int WC_W   = (MEM_LAT > 1)    ? $clog2(MEM_LAT)    : 1;
  localparam int JC_W   = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
  // Wide enough that y*MAP_W + x never overflows before the final cut.
  localparam int MUL_W  = ADDR_W + X_W + Y_W;

  localparam logic [X_W-1:0]  c_X_MAX     = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0]  c_Y_MAX     = Y_W'(MAP_H - 1);
  localparam logic [TC_W-1:0] c_TICK_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [WC_W-1:0] c_WAIT_LAST = WC_W'(MEM_LAT - 1);
  localparam logic [JC_W-1:0] c_JUMP_LAST = JC_W'(JUMP_TICKS - 1);

  typedef enum logic [2:0] {
    S_WAIT_TICK = 3'd0,
    S_H_ISSUE   = 3'd1,
    S_H_WAIT    = 3'd2,
    S_V_ISSUE   = 3'd3,
    S_V_WAIT    = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    VM_GROUND = 2'd0,
    VM_FALL   = 2'd1,
    VM_JUMP   = 2'd2
  } vmode_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seq_state_t        r_state,     w_state_nx;
  vmode_t            r_vmode,     w_vmode_nx;
  logic [X_W-1:0]    r_x,         w_x_nx;
  logic [Y_W-1:0]    r_y,         w_y_nx;
  logic [X_W-1:0]    r_cand_x,    w_cand_x_nx;
  logic [Y_W-1:0]    r_cand_y,    w_cand_y_nx;
  logic [JC_W-1:0]   r_jump_cnt,  w_jump_cnt_nx;
  logic [WC_W-1:0]   r_wait_cnt,  w_wait_cnt_nx;
  logic [3:0]        r_mov,       w_mov_nx;
  logic [ADDR_W-1:0] r_coll_addr, w_coll_addr_nx;
  logic [TC_W-1:0]   r_tick_cnt;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_tick;
  logic              w_wait_done;
  logic [3:0]        w_mov_eff;
  logic              w_left;
  logic              w_right;
  logic              w_h_valid;
  logic [X_W-1:0]    w_h_cand_x;
  logic [X_W-1:0]    w_x_post;
  logic              w_v_probe;
  logic [Y_W-1:0]    w_v_cand_y;
  logic [ADDR_W-1:0] w_h_addr;
  logic [ADDR_W-1:0] w_v_addr;
  logic              w_enter_v;
  logic              w_unused_down;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [X_W-1:0] x,
                                               input logic [Y_W-1:0] y);
    return ADDR_W'((MUL_W'(y) * MUL_W'(MAP_W)) + MUL_W'(x));
  endfunction

  assign w_tick      = (r_tick_cnt == c_TICK_LAST);
  assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);

  // In WAIT_TICK the keypad is being latched this very edge, so the
  // horizontal address is computed from the live input; afterwards the
  // latched copy is authoritative.
  assign w_mov_eff     = (r_state == S_WAIT_TICK) ? mov : r_mov;
  assign w_unused_down = w_mov_eff[2];

  // Pressing both or neither direction yields no horizontal candidate.
  assign w_left     = w_mov_eff[1] & ~w_mov_eff[0];
  assign w_right    = w_mov_eff[0] & ~w_mov_eff[1];
  assign w_h_valid  = (w_left && (r_x != '0)) || (w_right && (r_x != c_X_MAX));
  assign w_h_cand_x = w_left ? (r_x - X_W'(1)) : (r_x + X_W'(1));

  // X as it will be once the horizontal probe resolves; the vertical probe
  // address must use this value, not the pre-commit register.
  assign w_x_post = ((r_state == S_H_WAIT) && !coll.coll_data) ? r_cand_x : r_x;

  always_comb begin
    w_v_probe  = 1'b0;
    w_v_cand_y = r_y + Y_W'(1);
    case (r_vmode)
      VM_GROUND: w_v_probe = !w_mov_eff[3] && (r_y != c_Y_MAX);
      VM_FALL:   w_v_probe = (r_y != c_Y_MAX);
      VM_JUMP: begin
        w_v_probe  = (r_y != '0);
        w_v_cand_y = r_y - Y_W'(1);
      end
      default:   w_v_probe = 1'b0;
    endcase
  end

  assign w_h_addr = f_addr(w_h_cand_x, r_y);
  assign w_v_addr = f_addr(w_x_post, w_v_cand_y);

  // --------------------------------------------------------------------------
  // Sequencer next-state / datapath
  // Addresses are loaded on the edge that enters an ISSUE state, so the RAM
  // sees them during ISSUE and the sample lands exactly MEM_LAT cycles later
  // on the last WAIT cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx     = r_state;
    w_vmode_nx     = r_vmode;
    w_x_nx         = r_x;
    w_y_nx         = r_y;
    w_cand_x_nx    = r_cand_x;
    w_cand_y_nx    = r_cand_y;
    w_jump_cnt_nx  = r_jump_cnt;
    w_wait_cnt_nx  = r_wait_cnt;
    w_mov_nx       = r_mov;
    w_coll_addr_nx = r_coll_addr;
    w_enter_v      = 1'b0;

    case (r_state)
      S_WAIT_TICK: begin
        if (w_tick) begin
          w_state_nx = S_H_ISSUE;
          w_mov_nx   = mov;
          if (w_h_valid) begin
            w_coll_addr_nx = w_h_addr;
            w_cand_x_nx    = w_h_cand_x;
          end
        end
      end

      S_H_ISSUE: begin
        if (w_h_valid) begin
          w_state_nx    = S_H_WAIT;
          w_wait_cnt_nx = '0;
        end else begin
          w_enter_v = 1'b1;
        end
      end

      S_H_WAIT: begin
        if (w_wait_done) begin
          w_x_nx    = w_x_post;
          w_enter_v = 1'b1;
        end else begin
          w_wait_cnt_nx = r_wait_cnt + WC_W'(1);
        end
      end

      S_V_ISSUE: begin
        w_state_nx    = S_V_WAIT;
        w_wait_cnt_nx = '0;
      end

      S_V_WAIT: begin
        if (w_wait_done) begin
          w_state_nx = S_WAIT_TICK;
          case (r_vmode)
            VM_GROUND: begin
              if (!coll.coll_data) begin
                w_y_nx     = r_cand_y;
                w_vmode_nx = VM_FALL;
              end
            end
            VM_JUMP: begin
              if (coll.coll_data) begin
                w_vmode_nx = VM_FALL;
              end else begin
                w_y_nx        = r_cand_y;
                w_jump_cnt_nx = r_jump_cnt + JC_W'(1);
                if (r_jump_cnt == c_JUMP_LAST) begin
                  w_vmode_nx = VM_FALL;
                end
              end
            end
            VM_FALL: begin
              if (coll.coll_data) begin
                w_vmode_nx = VM_GROUND;
              end else begin
                w_y_nx = r_cand_y;
              end
            end
            default: w_vmode_nx = VM_FALL;
          endcase
        end else begin
          w_wait_cnt_nx = r_wait_cnt + WC_W'(1);
        end
      end

      default: w_state_nx = S_WAIT_TICK;
    endcase

    // Horizontal phase finished: either launch the vertical probe or apply
    // the probe-less vertical outcome (jump start, map edge) and go idle.
    if (w_enter_v) begin
      if (w_v_probe) begin
        w_state_nx     = S_V_ISSUE;
        w_coll_addr_nx = w_v_addr;
        w_cand_y_nx    = w_v_cand_y;
      end else begin
        w_state_nx = S_WAIT_TICK;
        case (r_vmode)
          VM_GROUND: begin
            if (w_mov_eff[3]) begin
              w_vmode_nx    = VM_JUMP;
              w_jump_cnt_nx = '0;
            end
          end
          VM_JUMP:   w_vmode_nx = VM_FALL;    // already at the top row
          VM_FALL:   w_vmode_nx = VM_GROUND;  // already at the bottom row
          default:   w_vmode_nx = VM_FALL;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT_TICK;
      r_vmode     <= VM_FALL;
      r_x         <= X_W'(START_X);
      r_y         <= Y_W'(START_Y);
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_jump_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_mov       <= '0;
      r_coll_addr <= '0;
      r_tick_cnt  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_vmode     <= w_vmode_nx;
      r_x         <= w_x_nx;
      r_y         <= w_y_nx;
      r_cand_x    <= w_cand_x_nx;
      r_cand_y    <= w_cand_y_nx;
      r_jump_cnt  <= w_jump_cnt_nx;
      r_wait_cnt  <= w_wait_cnt_nx;
      r_mov       <= w_mov_nx;
      r_coll_addr <= w_coll_addr_nx;
      r_tick_cnt  <= w_tick ? '0 : (r_tick_cnt + TC_W'(1));
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign coll.coll_addr = r_coll_addr;
  assign char_X         = r_x;
  assign char_Y         = r_y;
  assign vmode          = r_vmode;
  assign busy           = (r_state != S_WAIT_TICK);

endmodule
`default_nettype wire

// File: tb/tb_char_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_motion
// Purpose  : Directed self-checking bench for char_motion. A behavioural
//            collision RAM with a MEM_LAT-deep read pipeline answers probes
//            from a map made of an optional floor row, ceiling row and one
//            solid cell.
// Revision : 1.0  initial release
// ============================================================================
module tb_char_motion;

  localparam int TICK_DIV = 16;
  localparam int MEM_LAT  = 3;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] mov     = 4'd0;
  logic [9:0] char_X;
  logic [9:0] char_Y;
  logic [1:0] vmode;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int floor_row = -1;
  int ceil_row  = -1;
  int wall_addr = -1;
  logic [MEM_LAT-1:0] ram_pipe = '0;

  char_motion_if #(.ADDR_W(19)) cif ();

  char_motion #(
    .MAP_W(960), .MAP_H(500), .X_W(10), .Y_W(10),
    .TICK_DIV(TICK_DIV), .JUMP_TICKS(48), .MEM_LAT(MEM_LAT),
    .START_X(244), .START_Y(350)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .mov    (mov),
    .coll   (cif),
    .char_X (char_X),
    .char_Y (char_Y),
    .vmode  (vmode),
    .busy   (busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic f_solid(input logic [18:0] a);
    int ai;
    int ay;
    ai = int'(a);
    ay = ai / 960;
    return (ay == floor_row) || (ay == ceil_row) || (ai == wall_addr);
  endfunction

  always @(posedge sys_clk) ram_pipe <= {ram_pipe[MEM_LAT-2:0], f_solid(cif.coll_addr)};
  assign cif.coll_data = ram_pipe[MEM_LAT-1];

  task automatic step_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge sys_clk);
  endtask

  // Leaves the bench 12 cycles after reset release; every later
  // step_ticks(1) lands in the idle part of the next tick period.
  task automatic do_reset();
    rst = 1'b1;
    mov = 4'd0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (12) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mov = 4'd0;
    repeat (2) @(negedge sys_clk);
    n_tests++; if (char_X !== 10'd244) begin n_fail++; $display("FAIL reset_x: got %0d expected 244", char_X); end
    n_tests++; if (char_Y !== 10'd350) begin n_fail++; $display("FAIL reset_y: got %0d expected 350", char_Y); end
    n_tests++; if (vmode !== 2'd1) begin n_fail++; $display("FAIL reset_vmode: got %0d expected 1", vmode); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_tests++; if (cif.coll_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", cif.coll_addr); end
    rst = 1'b0;
    repeat (15) @(negedge sys_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_tick_early: busy %0b expected 0", busy); end
    @(negedge sys_clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_tick_on_time: busy %0b expected 1", busy); end
  endtask

  task automatic test_free_fall();
    int cnt;
    floor_row = -1; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd351) begin n_fail++; $display("FAIL fall_y1: got %0d expected 351", char_Y); end
    n_tests++; if (vmode !== 2'd1) begin n_fail++; $display("FAIL fall_vmode1: got %0d expected 1", vmode); end
    n_tests++; if (char_X !== 10'd244) begin n_fail++; $display("FAIL fall_x1: got %0d expected 244", char_X); end
    cnt = 0;
    repeat (TICK_DIV) begin @(negedge sys_clk); if (busy === 1'b1) cnt++; end
    n_tests++; if (cnt != 5) begin n_fail++; $display("FAIL fall_busy_width: got %0d expected 5", cnt); end
    n_tests++; if (char_Y !== 10'd352) begin n_fail++; $display("FAIL fall_y2: got %0d expected 352", char_Y); end
    step_ticks(147);
    n_tests++; if (char_Y !== 10'd499) begin n_fail++; $display("FAIL fall_y499: got %0d expected 499", char_Y); end
    n_tests++; if (vmode !== 2'd1) begin n_fail++; $display("FAIL fall_vmode_at_bottom: got %0d expected 1", vmode); end
    step_ticks(1);
    n_tests++; if (vmode !== 2'd0) begin n_fail++; $display("FAIL fall_landed: got %0d expected 0", vmode); end
    n_tests++; if (char_Y !== 10'd499) begin n_fail++; $display("FAIL fall_y_landed: got %0d expected 499", char_Y); end
    step_ticks(2);
    n_tests++; if (char_Y !== 10'd499 || vmode !== 2'd0) begin n_fail++; $display("FAIL fall_hold: got y=%0d vmode=%0d expected y=499 vmode=0", char_Y, vmode); end
  endtask

  task automatic test_wall_block();
    int cnt;
    floor_row = 351; ceil_row = -1; wall_addr = 336245;
    do_reset();
    step_ticks(1);
    n_tests++; if (vmode !== 2'd0 || char_Y !== 10'd350) begin n_fail++; $display("FAIL wall_grounded: got y=%0d vmode=%0d expected y=350 vmode=0", char_Y, vmode); end
    mov = 4'b0001;
    repeat (5) @(negedge sys_clk);
    n_tests++; if (cif.coll_addr !== 19'd336245) begin n_fail++; $display("FAIL wall_h_addr: got %0d expected 336245", cif.coll_addr); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wall_busy_in_wait: got %0b expected 1", busy); end
    repeat (11) @(negedge sys_clk);
    n_tests++; if (char_X !== 10'd244) begin n_fail++; $display("FAIL wall_x: got %0d expected 244", char_X); end
    n_tests++; if (cif.coll_addr !== 19'd337204) begin n_fail++; $display("FAIL wall_addr_hold: got %0d expected 337204", cif.coll_addr); end
    cnt = 0;
    repeat (TICK_DIV) begin @(negedge sys_clk); if (busy === 1'b1) cnt++; end
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL wall_busy_width: got %0d expected 8", cnt); end
    step_ticks(1);
    n_tests++; if (char_X !== 10'd244 || char_Y !== 10'd350) begin n_fail++; $display("FAIL wall_hold: got x=%0d y=%0d expected x=244 y=350", char_X, char_Y); end
    mov = 4'b0000;
  endtask

  task automatic test_move();
    floor_row = 351; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(1);
    mov = 4'b0001;
    step_ticks(1);
    n_tests++; if (char_X !== 10'd245) begin n_fail++; $display("FAIL move_right: got %0d expected 245", char_X); end
    mov = 4'b0010;
    step_ticks(2);
    n_tests++; if (char_X !== 10'd243) begin n_fail++; $display("FAIL move_left2: got %0d expected 243", char_X); end
    mov = 4'b0011;
    step_ticks(1);
    n_tests++; if (char_X !== 10'd243) begin n_fail++; $display("FAIL move_both: got %0d expected 243", char_X); end
    mov = 4'b0100;
    step_ticks(1);
    n_tests++; if (char_X !== 10'd243 || char_Y !== 10'd350 || vmode !== 2'd0) begin n_fail++; $display("FAIL move_down_noop: got x=%0d y=%0d vmode=%0d expected x=243 y=350 vmode=0", char_X, char_Y, vmode); end
    mov = 4'b0000;
  endtask

  task automatic test_edges();
    int cnt;
    floor_row = 351; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(1);
    mov = 4'b0010;
    step_ticks(244);
    n_tests++; if (char_X !== 10'd0) begin n_fail++; $display("FAIL edge_reach_left: got %0d expected 0", char_X); end
    cnt = 0;
    repeat (TICK_DIV) begin @(negedge sys_clk); if (busy === 1'b1) cnt++; end
    n_tests++; if (cnt != 5) begin n_fail++; $display("FAIL edge_left_busy: got %0d expected 5", cnt); end
    n_tests++; if (char_X !== 10'd0) begin n_fail++; $display("FAIL edge_left_hold: got %0d expected 0", char_X); end
    mov = 4'b0001;
    step_ticks(959);
    n_tests++; if (char_X !== 10'd959) begin n_fail++; $display("FAIL edge_reach_right: got %0d expected 959", char_X); end
    cnt = 0;
    repeat (TICK_DIV) begin @(negedge sys_clk); if (busy === 1'b1) cnt++; end
    n_tests++; if (cnt != 5) begin n_fail++; $display("FAIL edge_right_busy: got %0d expected 5", cnt); end
    n_tests++; if (char_X !== 10'd959) begin n_fail++; $display("FAIL edge_right_hold: got %0d expected 959", char_X); end
    mov = 4'b0000;
  endtask

  task automatic test_jump();
    int cnt;
    floor_row = 401; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(51);
    n_tests++; if (char_Y !== 10'd400 || vmode !== 2'd0) begin n_fail++; $display("FAIL jump_pre_ground: got y=%0d vmode=%0d expected y=400 vmode=0", char_Y, vmode); end
    mov = 4'b1000;
    cnt = 0;
    repeat (TICK_DIV) begin @(negedge sys_clk); if (busy === 1'b1) cnt++; end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL jump_start_busy: got %0d expected 1", cnt); end
    n_tests++; if (vmode !== 2'd2 || char_Y !== 10'd400) begin n_fail++; $display("FAIL jump_start: got y=%0d vmode=%0d expected y=400 vmode=2", char_Y, vmode); end
    mov = 4'b0000;
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd399 || vmode !== 2'd2) begin n_fail++; $display("FAIL jump_rise1: got y=%0d vmode=%0d expected y=399 vmode=2", char_Y, vmode); end
    step_ticks(46);
    n_tests++; if (char_Y !== 10'd353 || vmode !== 2'd2) begin n_fail++; $display("FAIL jump_rise47: got y=%0d vmode=%0d expected y=353 vmode=2", char_Y, vmode); end
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd352 || vmode !== 2'd1) begin n_fail++; $display("FAIL jump_apex: got y=%0d vmode=%0d expected y=352 vmode=1", char_Y, vmode); end
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd353 || vmode !== 2'd1) begin n_fail++; $display("FAIL jump_descend: got y=%0d vmode=%0d expected y=353 vmode=1", char_Y, vmode); end
    step_ticks(48);
    n_tests++; if (char_Y !== 10'd400 || vmode !== 2'd0) begin n_fail++; $display("FAIL jump_land: got y=%0d vmode=%0d expected y=400 vmode=0", char_Y, vmode); end
  endtask

  task automatic test_ceiling();
    floor_row = 401; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(51);
    ceil_row = 398;
    mov = 4'b1000;
    step_ticks(1);
    mov = 4'b0000;
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd399 || vmode !== 2'd2) begin n_fail++; $display("FAIL ceil_rise: got y=%0d vmode=%0d expected y=399 vmode=2", char_Y, vmode); end
    step_ticks(1);
    n_tests++; if (char_Y !== 10'd399 || vmode !== 2'd1) begin n_fail++; $display("FAIL ceil_hit: got y=%0d vmode=%0d expected y=399 vmode=1", char_Y, vmode); end
    step_ticks(2);
    n_tests++; if (char_Y !== 10'd400 || vmode !== 2'd0) begin n_fail++; $display("FAIL ceil_land: got y=%0d vmode=%0d expected y=400 vmode=0", char_Y, vmode); end
    ceil_row = -1;
  endtask

  task automatic test_reset_mid_probe();
    floor_row = 351; ceil_row = -1; wall_addr = -1;
    do_reset();
    step_ticks(1);
    mov = 4'b0001;
    repeat (5) @(negedge sys_clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %0b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (char_X !== 10'd244 || char_Y !== 10'd350 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_abort: got x=%0d y=%0d busy=%0b expected x=244 y=350 busy=0", char_X, char_Y, busy); end
    n_tests++; if (vmode !== 2'd1 || cif.coll_addr !== 19'd0) begin n_fail++; $display("FAIL midrst_regs: got vmode=%0d addr=%0d expected vmode=1 addr=0", vmode, cif.coll_addr); end
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (15) @(negedge sys_clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_tick_early: busy %0b expected 0", busy); end
    @(negedge sys_clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_tick_on_time: busy %0b expected 1", busy); end
    repeat (12) @(negedge sys_clk);
    n_tests++; if (char_X !== 10'd245 || char_Y !== 10'd350 || vmode !== 2'd0) begin n_fail++; $display("FAIL midrst_resume: got x=%0d y=%0d vmode=%0d expected x=245 y=350 vmode=0", char_X, char_Y, vmode); end
    mov = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_free_fall();
    test_wall_block();
    test_move();
    test_edges();
    test_jump();
    test_ceiling();
    test_reset_mid_probe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/char_motion.md
CHAR_MOTION -- requirements
Module: char_motion

Interface
REQ-001 SHALL have parameter MAP_W, default 960, map width in pixels.
REQ-002 SHALL have parameter MAP_H, default 500, map height in pixels.
REQ-003 SHALL have parameter X_W, default 10, width of char_X.
REQ-004 SHALL have parameter Y_W, default 10, width of char_Y.
REQ-005 SHALL have parameter TICK_DIV, default 200000, sys_clk cycles per motion tick.
REQ-006 SHALL have parameter JUMP_TICKS, default 48, maximum rising ticks per jump.
REQ-007 SHALL have parameter MEM_LAT, default 1, collision-RAM read latency in cycles.
REQ-008 SHALL have parameters START_X, default 244, and START_Y, default 350, giving the spawn position.
REQ-009 SHALL have derived localparam ADDR_W = clog2(MAP_W*MAP_H).
REQ-010 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-011 rst  input  1  reset; asynchronous, active-high.
REQ-012 mov  input  4  keypad bits {up, down, left, right} = mov[3:0]; sampled once at tick start.
REQ-013 coll_addr  output  ADDR_W  collision-RAM read address.
REQ-014 coll_data  input  1  collision bit (1 = solid); valid MEM_LAT cycles after coll_addr.
REQ-015 char_X  output  X_W  character X position.
REQ-016 char_Y  output  Y_W  character Y position.
REQ-017 vmode  output  2  vertical mode: 0 GROUND, 1 FALL, 2 JUMP.
REQ-018 busy  output  1  high while the current tick's probe sequence is in progress.

Function
REQ-019 SHALL assert a one-cycle tick every TICK_DIV sys_clk cycles, using a free-running counter that wraps from TICK_DIV-1 to 0.
REQ-020 Sequencer states: WAIT_TICK, H_ISSUE, H_WAIT, V_ISSUE, V_WAIT; on tick, WAIT_TICK SHALL go to H_ISSUE and latch mov.
REQ-021 Horizontal candidate rules:
- left only and char_X>0: char_X-1.
- right only and char_X<MAP_W-1: char_X+1.
- Otherwise, including both or neither pressed: no candidate, and the sequencer skips directly to V_ISSUE.
REQ-022 Probe sequence:
- ISSUE drives coll_addr = candY*MAP_W + candX, with full-width multiply, no truncation before ADDR_W.
- WAIT holds the address for exactly MEM_LAT cycles, then samples coll_data.
- coll_data=0 commits the candidate; coll_data=1 discards it.
REQ-023 The vertical probe SHALL use the post-horizontal-commit char_X.
REQ-024 Vertical candidates:
- JUMP: char_Y-1.
- FALL and GROUND: char_Y+1.
REQ-025 GROUND transitions:
- mov[3]=1: go to JUMP with jump_cnt=0, and no vertical probe this tick.
- Otherwise probe below. If clear, commit Y+1 and go to FALL. If solid, or char_Y=MAP_H-1, stay in GROUND.
REQ-026 JUMP transitions:
- char_Y=0 or probe solid: go to FALL with no Y change.
- Clear: commit Y-1 and increment jump_cnt; when jump_cnt reaches JUMP_TICKS-1, go to FALL.
REQ-027 FALL transitions:
- char_Y=MAP_H-1: go to GROUND.
- Probe solid: go to GROUND with no Y change.
- Clear: commit Y+1.
REQ-028 mov[2] (down) SHALL have no effect.
REQ-029 char_X/char_Y SHALL change only in the commit cycle after a WAIT, by at most 1 each per tick.
REQ-030 busy SHALL be high from H_ISSUE through the last WAIT, and low in WAIT_TICK.
REQ-031 A tick arriving while busy=1 SHALL be dropped; a legal configuration requires TICK_DIV > 2*(MEM_LAT+2).
REQ-032 coll_addr SHALL hold its last value in WAIT_TICK.

Reset
REQ-033 On rst the block SHALL set:
- char_X=START_X, char_Y=START_Y.
- vmode=FALL, jump_cnt=0.
- sequencer state WAIT_TICK, tick counter 0.
- busy=0, coll_addr=0.
REQ-034 rst asserted mid-probe SHALL abort the sequence immediately with no partial commit, and the first tick after release SHALL occur TICK_DIV cycles later.

Verification
REQ-035 Free fall:
- Stimulus: empty map, mov=0, reset at START_Y=350.
- Response: char_Y increments once per tick to 499, then vmode=GROUND and Y holds at 499.
REQ-036 Wall block:
- Stimulus: solid at (245,350), char on ground at (244,350), mov=0001.
- Response: char_X stays 244 every tick and coll_addr=350*960+245=336245 during H_WAIT.
REQ-037 Jump:
- Stimulus: GROUND at Y=400, open ceiling, mov=1000 for one tick.
- Response: Y decreases 48 ticks to 352, then vmode=FALL and Y increases back to ground.
REQ-038 Ceiling hit:
- Stimulus: JUMP with solid at Y-1.
- Response: Y unchanged and vmode=FALL the same tick.
REQ-039 Edges:
- X=0 with mov=0010, or X=959 with mov=0001: no probe issued (busy only for the vertical probe) and X unchanged.
- mov=0011: X unchanged.
REQ-040 Latency and reset:
- With MEM_LAT=3, coll_data is sampled exactly 3 cycles after ISSUE.
- rst pulsed during H_WAIT gives char_X=244, char_Y=350, busy=0 in the same cycle.
